// File: rtl/j1_io_fabric.sv
// J1 I/O fabric: programmable page decode feeding a registered transaction FSM
// with per-slave ack or fixed-latency completion, timeout and sticky error capture.
module j1_io_fabric #(
    parameter int unsigned                   N_SLAVES     = 4,
    parameter int unsigned                   ADDR_W       = 16,
    parameter int unsigned                   DATA_W       = 16,
    parameter int unsigned                   PAGE_BITS    = 8,
    parameter logic [N_SLAVES*PAGE_BITS-1:0] SLAVE_PAGES  = {8'h70, 8'h69, 8'h68, 8'h67},
    parameter logic [N_SLAVES-1:0]           ACK_MASK     = 4'b0000,
    parameter int unsigned                   FIXED_LAT    = 1,
    parameter int unsigned                   TIMEOUT      = 64,
    parameter logic [DATA_W-1:0]             DEFAULT_DATA = 16'h0666
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    input  logic                          m_rd,
    input  logic                          m_wr,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_valid,
    output logic                          m_busy,
    output logic                          m_err,
    output logic [N_SLAVES-1:0]           s_cs,
    output logic                          s_rd,
    output logic                          s_wr,
    output logic [ADDR_W-PAGE_BITS-1:0]   s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0]    s_rdata,
    input  logic [N_SLAVES-1:0]           s_ack,
    output logic [1:0]                    err_code,
    output logic [ADDR_W-1:0]             err_addr,
    output logic                          err_irq,
    input  logic                          err_clr
);

    localparam int unsigned OFS_W = ADDR_W - PAGE_BITS;
    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(FIXED_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               rd_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               ack_now;
    logic [DATA_W-1:0]  sel_rdata;

    logic               latch;
    logic               err_ev;
    logic [1:0]         err_code_d;
    logic [ADDR_W-1:0]  err_addr_d;
    logic               rdata_ld;
    logic [DATA_W-1:0]  rdata_d;

    // Lowest matching index wins when pages are duplicated.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!hit && m_addr[ADDR_W-1 -: PAGE_BITS] == SLAVE_PAGES[i*PAGE_BITS +: PAGE_BITS]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign ack_now   = ACK_MASK[idx_q] ? s_ack[idx_q] : (cnt_q == LAT_LAST);
    assign sel_rdata = s_rdata[idx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        err_ev     = 1'b0;
        err_code_d = 2'b00;
        err_addr_d = addr_q;
        rdata_ld   = 1'b0;
        rdata_d    = DEFAULT_DATA;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (m_rd && m_wr) begin
                    latch      = 1'b1;
                    err_ev     = 1'b1;
                    err_code_d = 2'b11;
                    err_addr_d = m_addr;
                    rdata_ld   = 1'b1;
                    state_d    = S_ERR;
                end else if (m_rd || m_wr) begin
                    latch = 1'b1;
                    if (hit) begin
                        state_d = S_ACCESS;
                    end else begin
                        err_ev     = 1'b1;
                        err_code_d = 2'b01;
                        err_addr_d = m_addr;
                        rdata_ld   = m_rd;
                        state_d    = S_ERR;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack is tested first so an ack in the last WAIT cycle still completes.
                if (ack_now) begin
                    rdata_ld = rd_q;
                    rdata_d  = sel_rdata;
                    state_d  = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_ev     = 1'b1;
                    err_code_d = 2'b10;
                    rdata_ld   = rd_q;
                    state_d    = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            idx_q    <= '0;
            m_rdata  <= '0;
            err_code <= 2'b00;
            err_addr <= '0;
            err_irq  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                rd_q    <= m_rd;
                idx_q   <= hit_idx;
            end
            if (rdata_ld) m_rdata <= rdata_d;
            if (err_ev) err_addr <= err_addr_d;
            // A clear coinciding with a new error leaves the flag and code clear.
            if (err_clr) begin
                err_irq  <= 1'b0;
                err_code <= 2'b00;
            end else if (err_ev) begin
                err_irq  <= 1'b1;
                err_code <= err_code_d;
            end
        end
    end

    always_comb begin
        s_cs = '0;
        if (state_q == S_ACCESS || state_q == S_WAIT) s_cs[idx_q] = 1'b1;
    end

    assign s_rd    = (state_q == S_ACCESS) && rd_q;
    assign s_wr    = (state_q == S_ACCESS) && !rd_q;
    assign s_addr  = addr_q[OFS_W-1:0];
    assign s_wdata = wdata_q;
    assign m_busy  = (state_q != S_IDLE);
    assign m_err   = (state_q == S_ERR);
    assign m_valid = ((state_q == S_DONE) || (state_q == S_ERR)) && rd_q;

endmodule

// File: tb/tb_j1_io_fabric.sv
// Bench for j1_io_fabric: directed vector table, hand sequences for clear/reset
// corners, and random transactions checked against a transaction-level model.
module tb_j1_io_fabric;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 8;
    localparam int unsigned FLAT = 1;
    localparam int BUDGET = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      m_addr, m_wdata, m_rdata;
    logic             m_rd, m_wr, m_valid, m_busy, m_err;
    logic [N-1:0]     s_cs, s_ack;
    logic             s_rd, s_wr;
    logic [7:0]       s_addr;
    logic [15:0]      s_wdata;
    logic [N*DW-1:0]  s_rdata;
    logic [1:0]       err_code;
    logic [15:0]      err_addr;
    logic             err_irq, err_clr;

    always #5 clk = ~clk;

    j1_io_fabric #(
        .N_SLAVES(4), .ADDR_W(16), .DATA_W(16), .PAGE_BITS(8),
        .SLAVE_PAGES(32'h70696867), .ACK_MASK(4'b0101),
        .FIXED_LAT(1), .TIMEOUT(8), .DEFAULT_DATA(16'h0666)
    ) dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
        .m_rdata(m_rdata), .m_valid(m_valid), .m_busy(m_busy), .m_err(m_err),
        .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .err_code(err_code), .err_addr(err_addr), .err_irq(err_irq), .err_clr(err_clr)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] word;
        int          slot;
        int          ack_slot;
        int          ack_delay;
        logic        noise;
        logic        breq;
        int          exp_end;
        logic        exp_valid;
        logic        exp_err;
        logic [15:0] exp_rdata;
        logic [1:0]  exp_code;
        logic [3:0]  exp_cs;
    } vec_t;

    int tests, fails;
    int r_end, r_vcnt, r_ecnt, r_rd_cnt, r_wr_cnt;
    logic [15:0] r_rdata, r_eaddr, r_swdata1;
    logic [7:0]  r_saddr1, r_saddr_end;
    logic [1:0]  r_code;
    logic        r_irq;
    logic [3:0]  r_cs_or;

    vec_t tv[10];
    logic [7:0] pages[4] = '{8'h67, 8'h68, 8'h69, 8'h70};
    bit         ack_type[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ack_vec(input vec_t v, input int c);
        logic [3:0] a;
        a = v.noise ? 4'($urandom) : 4'b0000;
        if (v.ack_slot >= 0 && c != 1)
            a[v.ack_slot] = (v.ack_delay != 0) && (c == 1 + v.ack_delay);
        return a;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [N*DW-1:0] rdw;
        bit done;
        rdw = {$urandom, $urandom};
        if (v.slot >= 0) rdw[v.slot*DW +: DW] = v.word;
        s_rdata = rdw;
        r_end = 0; r_vcnt = 0; r_ecnt = 0; r_rd_cnt = 0; r_wr_cnt = 0;
        r_cs_or = '0; r_saddr1 = '0; r_swdata1 = '0; r_saddr_end = '0;
        m_addr = v.addr; m_rd = v.rd; m_wr = v.wr; m_wdata = v.wdata;
        s_ack = ack_vec(v, 0);
        done = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            step();
            if (m_valid) r_vcnt++;
            if (m_err) r_ecnt++;
            if (s_rd) r_rd_cnt++;
            if (s_wr) r_wr_cnt++;
            r_cs_or |= s_cs;
            if (c == 1) begin
                r_saddr1  = s_addr;
                r_swdata1 = s_wdata;
            end
            if (!m_busy) begin
                done = 1;
                break;
            end
            r_end = c; r_rdata = m_rdata; r_code = err_code;
            r_eaddr = err_addr; r_irq = err_irq; r_saddr_end = s_addr;
            m_rd = 1'b0; m_wr = 1'b0;
            if (c == 2 && v.breq) begin
                m_addr = 16'h1234; m_rd = 1'b1; m_wdata = 16'($urandom);
            end
            s_ack = ack_vec(v, c);
        end
        m_rd = 1'b0; m_wr = 1'b0; s_ack = '0;
        if (!done) check("busy_bound", {31'b0, m_busy}, 32'd0);
    endtask

    task automatic check_txn(input vec_t v, input string tag);
        check($sformatf("%s end", tag), r_end, v.exp_end);
        check($sformatf("%s valid", tag), r_vcnt, {31'b0, v.exp_valid});
        check($sformatf("%s err", tag), r_ecnt, {31'b0, v.exp_err});
        check($sformatf("%s rdata", tag), r_rdata, v.exp_rdata);
        check($sformatf("%s cs", tag), r_cs_or, v.exp_cs);
        check($sformatf("%s s_rd", tag), r_rd_cnt, (v.exp_cs != 0 && v.rd) ? 1 : 0);
        check($sformatf("%s s_wr", tag), r_wr_cnt, (v.exp_cs != 0 && v.wr) ? 1 : 0);
        if (v.exp_err) begin
            check($sformatf("%s code", tag), r_code, v.exp_code);
            check($sformatf("%s eaddr", tag), r_eaddr, v.addr);
            check($sformatf("%s irq", tag), r_irq, 1);
        end
        if (v.exp_cs != 0) begin
            check($sformatf("%s s_addr", tag), r_saddr1, v.addr[7:0]);
            check($sformatf("%s s_addr_hold", tag), r_saddr_end, v.addr[7:0]);
            if (v.wr) check($sformatf("%s s_wdata", tag), r_swdata1, v.wdata);
        end
    endtask

    function automatic int find_slave(input logic [7:0] pg);
        for (int i = 0; i < 4; i++)
            if (pages[i] == pg) return i;
        return -1;
    endfunction

    initial begin
        vec_t v;
        logic [15:0] prev;
        int vc;
        tests = 0; fails = 0;
        m_addr = '0; m_wdata = '0; m_rd = 1'b0; m_wr = 1'b0;
        err_clr = 1'b0; s_rdata = '0; s_ack = '0;

        tv[0] = '{16'h6803, 1'b1, 1'b0, 16'h0000, 16'h1234,  1, -1, 0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 16'h1234, 2'b00, 4'b0010};
        tv[1] = '{16'h6905, 1'b0, 1'b1, 16'hBEEF, 16'h0000,  2,  2, 5, 1'b1, 1'b1,  7, 1'b0, 1'b0, 16'h1234, 2'b00, 4'b0100};
        tv[2] = '{16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, -1, -1, 0, 1'b1, 1'b0,  1, 1'b1, 1'b1, 16'h0666, 2'b01, 4'b0000};
        tv[3] = '{16'h6700, 1'b1, 1'b0, 16'h0000, 16'h7777,  0,  0, 0, 1'b1, 1'b1, 10, 1'b1, 1'b1, 16'h0666, 2'b10, 4'b0001};
        tv[4] = '{16'h6700, 1'b1, 1'b0, 16'h0000, 16'h5A5A,  0,  0, 8, 1'b1, 1'b0, 10, 1'b1, 1'b0, 16'h5A5A, 2'b00, 4'b0001};
        tv[5] = '{16'h7000, 1'b1, 1'b1, 16'h4444, 16'h9999,  3, -1, 0, 1'b1, 1'b0,  1, 1'b1, 1'b1, 16'h0666, 2'b11, 4'b0000};
        tv[6] = '{16'h7011, 1'b0, 1'b1, 16'h1357, 16'h0000,  3, -1, 0, 1'b1, 1'b1,  3, 1'b0, 1'b0, 16'h0666, 2'b00, 4'b1000};
        tv[7] = '{16'h0000, 1'b0, 1'b1, 16'h2468, 16'h0000, -1, -1, 0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 16'h0666, 2'b01, 4'b0000};
        tv[8] = '{16'h6700, 1'b1, 1'b0, 16'h0000, 16'hC3C3,  0,  0, 1, 1'b1, 1'b0,  3, 1'b1, 1'b0, 16'hC3C3, 2'b00, 4'b0001};
        tv[9] = '{16'h69FF, 1'b1, 1'b0, 16'h0000, 16'h0F0F,  2,  2, 8, 1'b1, 1'b0, 10, 1'b1, 1'b0, 16'h0F0F, 2'b00, 4'b0100};

        step();
        check("rst m_rdata", m_rdata, 16'h0000);
        check("rst m_busy", {31'b0, m_busy}, 0);
        check("rst m_valid", {31'b0, m_valid}, 0);
        check("rst m_err", {31'b0, m_err}, 0);
        check("rst s_cs", s_cs, 4'b0000);
        check("rst err_code", err_code, 2'b00);
        check("rst err_addr", err_addr, 16'h0000);
        check("rst err_irq", {31'b0, err_irq}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_txn(tv[i]);
            check_txn(tv[i], $sformatf("tv%0d", i));
        end

        // Clear coinciding with a new error: clear wins, err_addr still updates.
        check("irq before clr", {31'b0, err_irq}, 1);
        m_addr = 16'h2222; m_rd = 1'b1; err_clr = 1'b1;
        step();
        m_rd = 1'b0; err_clr = 1'b0;
        check("clr+err m_err", {31'b0, m_err}, 1);
        check("clr+err irq", {31'b0, err_irq}, 0);
        check("clr+err code", err_code, 2'b00);
        check("clr+err eaddr", err_addr, 16'h2222);
        check("clr+err rdata", m_rdata, 16'h0666);
        step();
        m_addr = 16'h3333; m_wr = 1'b1;
        step();
        m_wr = 1'b0;
        check("next err irq", {31'b0, err_irq}, 1);
        check("next err code", err_code, 2'b01);
        check("next err valid", {31'b0, m_valid}, 0);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr irq", {31'b0, err_irq}, 0);
        check("clr code", err_code, 2'b00);
        check("clr eaddr kept", err_addr, 16'h3333);

        // Reset asserted mid-WAIT.
        m_addr = 16'h6700; m_rd = 1'b1;
        step();
        m_rd = 1'b0;
        step();
        step();
        check("pre-rst cs", s_cs, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("mid-rst cs", s_cs, 4'b0000);
        check("mid-rst busy", {31'b0, m_busy}, 0);
        check("mid-rst rdata", m_rdata, 16'h0000);
        check("mid-rst eaddr", err_addr, 16'h0000);
        check("mid-rst s_addr", s_addr, 8'h00);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        vc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (m_valid) vc++;
        end
        check("no valid after rst", vc, 0);
        v = '{16'h6803, 1'b1, 1'b0, 16'h0000, 16'hABCD, 1, -1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 16'hABCD, 2'b00, 4'b0010};
        run_txn(v);
        check_txn(v, "post-rst");
        prev = 16'hABCD;

        for (int k = 0; k < 200; k++) begin
            int sl, d, n, sel;
            logic [7:0] pg;
            bit err_to;
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) pg = 8'($urandom_range(0, 8'h66));
            else pg = pages[$urandom_range(0, 3)];
            v.addr  = {pg, 8'($urandom)};
            v.rd    = (sel == 0) ? 1'b1 : 1'(sel % 2);
            v.wr    = (sel == 0) ? 1'b1 : !v.rd;
            v.wdata = 16'($urandom);
            v.word  = 16'($urandom);
            v.noise = 1'b1;
            v.breq  = 1'($urandom);
            sl = find_slave(pg);
            d  = $urandom_range(1, TMO + 2);
            v.slot = sl;
            v.ack_slot  = (sl >= 0 && ack_type[sl]) ? sl : -1;
            v.ack_delay = (d <= TMO) ? d : 0;
            v.exp_code = 2'b00;
            if (v.rd && v.wr) begin
                v.exp_end = 1; v.exp_valid = 1'b1; v.exp_err = 1'b1;
                v.exp_rdata = 16'h0666; v.exp_code = 2'b11; v.exp_cs = '0;
            end else if (sl < 0) begin
                v.exp_end = 1; v.exp_valid = v.rd; v.exp_err = 1'b1;
                v.exp_rdata = v.rd ? 16'h0666 : prev; v.exp_code = 2'b01; v.exp_cs = '0;
            end else begin
                err_to = ack_type[sl] && (d > TMO);
                n = ack_type[sl] ? (err_to ? TMO : d) : FLAT;
                v.exp_end = 2 + n; v.exp_valid = v.rd; v.exp_err = err_to;
                v.exp_cs = 4'(1 << sl);
                if (err_to) begin
                    v.exp_code = 2'b10;
                    v.exp_rdata = v.rd ? 16'h0666 : prev;
                end else begin
                    v.exp_rdata = v.rd ? v.word : prev;
                end
            end
            run_txn(v);
            check_txn(v, $sformatf("rnd%0d", k));
            prev = v.exp_rdata;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
